// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared processor definitions used by the hazard controller: operand
// forwarding encodings, hazard FSM states and the in-flight scoreboard entry.
package pipeline_hazard_controller_pkg;

   // Scoreboard destination field width; register addresses up to this width
   // are zero-extended into it, so REG_ADDR_W must not exceed it.
   localparam int SB_DST_W = 8;

   // Operand source select driven towards the ALU operand muxes.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,   // register file
      FWD_ALU = 2'b01,   // ALU stage result (scoreboard entry E)
      FWD_MEM = 2'b10,   // memory stage result (scoreboard entry M)
      FWD_WB  = 2'b11    // writeback value (scoreboard entry W)
   } fwd_sel_e;

   // Load-use stall FSM states.
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } hz_state_e;

   // One in-flight instruction as tracked by the scoreboard.
   typedef struct packed {
      logic                valid;
      logic                wb;
      logic                mem_read;
      logic [SB_DST_W-1:0] dst;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

   // True when the entry will produce the value of register src.
   function automatic logic sb_hit(input sb_entry_t e, input logic [SB_DST_W-1:0] src);
      return e.valid & e.wb & (e.dst == src);
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// Forwarding priority for one source operand: the youngest producer wins
// (ALU stage over memory stage over writeback).
module forward_select
   import pipeline_hazard_controller_pkg::*;
(
   input  logic                i_src_used,
   input  logic [SB_DST_W-1:0] i_src,
   input  sb_entry_t           i_ent_e,
   input  sb_entry_t           i_ent_m,
   input  sb_entry_t           i_ent_w,
   output fwd_sel_e            o_fwd_sel
);

   // Priority select over the three scoreboard entries.
   always_comb begin
      o_fwd_sel = FWD_RF;
      if (i_src_used) begin
         if (sb_hit(i_ent_e, i_src)) begin
            o_fwd_sel = FWD_ALU;
         end else if (sb_hit(i_ent_m, i_src)) begin
            o_fwd_sel = FWD_MEM;
         end else if (sb_hit(i_ent_w, i_src)) begin
            o_fwd_sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a short in-order pipeline: tracks in-flight writers in
// a 3-entry scoreboard, selects operand forwarding, inserts load-use stalls
// and flushes on taken jumps. All control outputs are combinational.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int REG_ADDR_W        = 3,
   parameter int CNT_W             = 16,
   parameter int LOAD_STALL_CYCLES = 1    // 1..7
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dec_valid,
   input  logic                  dec_wb,
   input  logic                  dec_mem_read,
   input  logic [REG_ADDR_W-1:0] dec_src1,
   input  logic [REG_ADDR_W-1:0] dec_src2,
   input  logic [REG_ADDR_W-1:0] dec_dst,
   input  logic                  dec_src1_used,
   input  logic                  dec_src2_used,
   input  logic                  ex_jump_taken,
   output logic                  stall_fetch,
   output logic                  stall_decode,
   output logic                  bubble_ex,
   output logic                  flush_fd,
   output logic                  flush_de,
   output logic [1:0]            fwd_sel1,
   output logic [1:0]            fwd_sel2,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count,
   output hz_state_e             dbg_state
);

   sb_entry_t           r_sb_e, r_sb_m, r_sb_w;
   hz_state_e           r_state;
   hz_state_e           w_state_nxt;
   logic [2:0]          r_stall_cnt;
   logic [2:0]          w_stall_cnt_nxt;
   logic [CNT_W-1:0]    r_stall_count, r_flush_count;

   logic [SB_DST_W-1:0] w_src1, w_src2;
   sb_entry_t           w_dec_entry;
   logic                w_issue;
   logic                w_load_use;
   logic                w_stall;
   logic                w_flush;
   fwd_sel_e            w_fwd1_raw, w_fwd2_raw;

   assign w_src1      = SB_DST_W'(dec_src1);
   assign w_src2      = SB_DST_W'(dec_src2);
   assign w_dec_entry = '{valid: 1'b1, wb: dec_wb, mem_read: dec_mem_read,
                          dst: SB_DST_W'(dec_dst)};
   assign w_issue     = dec_valid & ~stall_decode & ~flush_de;

   // A load in the ALU stage whose result decode needs right now.
   assign w_load_use = r_sb_e.valid & r_sb_e.wb & r_sb_e.mem_read &
                       ((dec_src1_used & (r_sb_e.dst == w_src1)) |
                        (dec_src2_used & (r_sb_e.dst == w_src2)));

   // Scoreboard shift: decode issue enters E, older entries age towards W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sb_e <= SB_EMPTY;
         r_sb_m <= SB_EMPTY;
         r_sb_w <= SB_EMPTY;
      end else begin
         r_sb_w <= r_sb_m;
         r_sb_m <= r_sb_e;
         r_sb_e <= w_issue ? w_dec_entry : SB_EMPTY;
      end
   end

   // FSM state and remaining-stall counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_RUN;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
      end
   end

   // Next state: a taken jump always wins; extra stall cycles count down.
   always_comb begin
      w_state_nxt     = r_state;
      w_stall_cnt_nxt = r_stall_cnt;
      if (ex_jump_taken) begin
         w_state_nxt     = ST_RUN;
         w_stall_cnt_nxt = '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_load_use && (LOAD_STALL_CYCLES > 1)) begin
                  w_state_nxt     = ST_STALL;
                  w_stall_cnt_nxt = 3'(LOAD_STALL_CYCLES - 1);
               end
            end
            ST_STALL: begin
               w_stall_cnt_nxt = r_stall_cnt - 3'd1;
               if (r_stall_cnt <= 3'd1) begin
                  w_state_nxt     = ST_RUN;
                  w_stall_cnt_nxt = '0;
               end
            end
            default: begin
               w_state_nxt     = ST_RUN;
               w_stall_cnt_nxt = '0;
            end
         endcase
      end
   end

   // Outputs: flush overrides stall; everything is held low during reset.
   always_comb begin
      w_stall = 1'b0;
      w_flush = 1'b0;
      if (ex_jump_taken) begin
         w_flush = 1'b1;
      end else begin
         case (r_state)
            ST_RUN:   w_stall = w_load_use;
            ST_STALL: w_stall = 1'b1;
            default:  w_stall = 1'b0;
         endcase
      end
      stall_fetch  = reset & w_stall;
      stall_decode = reset & w_stall;
      bubble_ex    = reset & w_stall;
      flush_fd     = reset & w_flush;
      flush_de     = reset & w_flush;
   end

   forward_select u_fwd1 (
      .i_src_used (dec_src1_used),
      .i_src      (w_src1),
      .i_ent_e    (r_sb_e),
      .i_ent_m    (r_sb_m),
      .i_ent_w    (r_sb_w),
      .o_fwd_sel  (w_fwd1_raw)
   );

   forward_select u_fwd2 (
      .i_src_used (dec_src2_used),
      .i_src      (w_src2),
      .i_ent_e    (r_sb_e),
      .i_ent_m    (r_sb_m),
      .i_ent_w    (r_sb_w),
      .o_fwd_sel  (w_fwd2_raw)
   );

   // Forwarding is meaningless for a squashed decode slot or during reset.
   always_comb begin
      fwd_sel1 = FWD_RF;
      fwd_sel2 = FWD_RF;
      if (reset && !flush_de) begin
         fwd_sel1 = w_fwd1_raw;
         fwd_sel2 = w_fwd2_raw;
      end
   end

   // Saturating stall and flush event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (stall_decode && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
         end
         if (ex_jump_taken && (r_flush_count != '1)) begin
            r_flush_count <= r_flush_count + CNT_W'(1);
         end
      end
   end

   assign stall_count = r_stall_count;
   assign flush_count = r_flush_count;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (1-cycle and 3-cycle
// load stalls, the latter with narrow counters) share one stimulus stream.
// A pipeline-list reference model predicts each cycle's outputs into per-DUT
// queues; a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;
   import pipeline_hazard_controller_pkg::*;

   // ---------------- clock / reset / signals ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       dec_valid, dec_wb, dec_mem_read;
   logic [2:0] dec_src1, dec_src2, dec_dst;
   logic       dec_src1_used, dec_src2_used, ex_jump_taken;

   logic        sf1, sd1, bx1, ffd1, fde1;
   logic [1:0]  f1_1, f2_1;
   logic [15:0] sc1, fc1;
   hz_state_e   dbg1;

   logic        sf3, sd3, bx3, ffd3, fde3;
   logic [1:0]  f1_3, f2_3;
   logic [3:0]  sc3, fc3;
   hz_state_e   dbg3;

   pipeline_hazard_controller #(.REG_ADDR_W(3), .CNT_W(16), .LOAD_STALL_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_wb(dec_wb),
      .dec_mem_read(dec_mem_read), .dec_src1(dec_src1), .dec_src2(dec_src2),
      .dec_dst(dec_dst), .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
      .ex_jump_taken(ex_jump_taken), .stall_fetch(sf1), .stall_decode(sd1),
      .bubble_ex(bx1), .flush_fd(ffd1), .flush_de(fde1), .fwd_sel1(f1_1),
      .fwd_sel2(f2_1), .stall_count(sc1), .flush_count(fc1), .dbg_state(dbg1)
   );

   pipeline_hazard_controller #(.REG_ADDR_W(3), .CNT_W(4), .LOAD_STALL_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_wb(dec_wb),
      .dec_mem_read(dec_mem_read), .dec_src1(dec_src1), .dec_src2(dec_src2),
      .dec_dst(dec_dst), .dec_src1_used(dec_src1_used), .dec_src2_used(dec_src2_used),
      .ex_jump_taken(ex_jump_taken), .stall_fetch(sf3), .stall_decode(sd3),
      .bubble_ex(bx3), .flush_fd(ffd3), .flush_de(fde3), .fwd_sel1(f1_3),
      .fwd_sel2(f2_3), .stall_count(sc3), .flush_count(fc3), .dbg_state(dbg3)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       v;
      logic       wb;
      logic       ld;
      logic [2:0] dst;
   } ins_t;

   typedef struct packed {
      logic [4:0]  ctl;   // stall_fetch, stall_decode, bubble_ex, flush_fd, flush_de
      logic [1:0]  f1;
      logic [1:0]  f2;
      logic        stl;   // FSM is in its extra-stall state
      logic [15:0] scnt;
      logic [15:0] fcnt;
   } exp_t;

   ins_t m_pipe [2][3];          // [dut][age]: age 0 = ALU stage
   int   m_left [2];             // stall cycles still owed after this one
   int   m_scnt [2];
   int   m_fcnt [2];
   logic m_stall [2];
   logic m_flush [2];
   logic m_hz [2];
   int   m_lsc [2]  = '{1, 3};
   int   m_cmax [2] = '{65535, 15};

   exp_t exp_q1[$];
   exp_t exp_q3[$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [1:0] ref_fwd(input int k, input logic used, input logic [2:0] src);
      if (!used) return 2'd0;
      for (int a = 0; a < 3; a++) begin
         if (m_pipe[k][a].v && m_pipe[k][a].wb && (m_pipe[k][a].dst == src)) return 2'(a + 1);
      end
      return 2'd0;
   endfunction

   task automatic model_clear(input int k);
      for (int a = 0; a < 3; a++) m_pipe[k][a] = '0;
      m_left[k] = 0;
      m_scnt[k] = 0;
      m_fcnt[k] = 0;
      m_stall[k] = 1'b0;
      m_flush[k] = 1'b0;
      m_hz[k] = 1'b0;
   endtask

   task automatic predict(input int k, output exp_t e);
      e = '0;
      m_hz[k] = m_pipe[k][0].v && m_pipe[k][0].wb && m_pipe[k][0].ld &&
                ((dec_src1_used && (dec_src1 == m_pipe[k][0].dst)) ||
                 (dec_src2_used && (dec_src2 == m_pipe[k][0].dst)));
      if (!reset) begin
         m_stall[k] = 1'b0;
         m_flush[k] = 1'b0;
      end else begin
         m_flush[k] = ex_jump_taken;
         m_stall[k] = !ex_jump_taken && ((m_left[k] > 0) || m_hz[k]);
         e.ctl  = {m_stall[k], m_stall[k], m_stall[k], m_flush[k], m_flush[k]};
         e.f1   = m_flush[k] ? 2'd0 : ref_fwd(k, dec_src1_used, dec_src1);
         e.f2   = m_flush[k] ? 2'd0 : ref_fwd(k, dec_src2_used, dec_src2);
         e.stl  = (m_left[k] > 0);
         e.scnt = 16'(m_scnt[k]);
         e.fcnt = 16'(m_fcnt[k]);
      end
   endtask

   task automatic update(input int k);
      if (!reset) begin
         model_clear(k);
      end else begin
         m_pipe[k][2] = m_pipe[k][1];
         m_pipe[k][1] = m_pipe[k][0];
         if (dec_valid && !m_stall[k] && !m_flush[k])
            m_pipe[k][0] = '{v: 1'b1, wb: dec_wb, ld: dec_mem_read, dst: dec_dst};
         else
            m_pipe[k][0] = '0;
         if (ex_jump_taken)   m_left[k] = 0;
         else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
         else if (m_hz[k])    m_left[k] = m_lsc[k] - 1;
         if (m_stall[k] && (m_scnt[k] < m_cmax[k])) m_scnt[k]++;
         if (ex_jump_taken && (m_fcnt[k] < m_cmax[k])) m_fcnt[k]++;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      exp_t e;
      predict(0, e); exp_q1.push_back(e);
      predict(1, e); exp_q3.push_back(e);
      @(posedge clk);
      update(0);
      update(1);
      #1;
   endtask

   task automatic idle();
      dec_valid = 0; dec_wb = 0; dec_mem_read = 0;
      dec_src1 = 0; dec_src2 = 0; dec_dst = 0;
      dec_src1_used = 0; dec_src2_used = 0; ex_jump_taken = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle();
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   task automatic issue(input logic wb, input logic ld, input logic [2:0] dst);
      idle();
      dec_valid = 1; dec_wb = wb; dec_mem_read = ld; dec_dst = dst;
      cycle();
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : mon
      exp_t e;
      exp_t a;
      if (exp_q1.size() > 0) begin
         e = exp_q1.pop_front();
         a = '{ctl: {sf1, sd1, bx1, ffd1, fde1}, f1: f1_1, f2: f2_1,
               stl: (dbg1 == ST_STALL), scnt: sc1, fcnt: fc1};
         chk("dut1_ctl", {7'd0, a.ctl, a.f1, a.f2}, {7'd0, e.ctl, e.f1, e.f2});
         chk("dut1_state", {15'd0, a.stl}, {15'd0, e.stl});
         chk("dut1_stall_count", a.scnt, e.scnt);
         chk("dut1_flush_count", a.fcnt, e.fcnt);
      end
      if (exp_q3.size() > 0) begin
         e = exp_q3.pop_front();
         a = '{ctl: {sf3, sd3, bx3, ffd3, fde3}, f1: f1_3, f2: f2_3,
               stl: (dbg3 == ST_STALL), scnt: {12'd0, sc3}, fcnt: {12'd0, fc3}};
         chk("dut3_ctl", {7'd0, a.ctl, a.f1, a.f2}, {7'd0, e.ctl, e.f1, e.f2});
         chk("dut3_state", {15'd0, a.stl}, {15'd0, e.stl});
         chk("dut3_stall_count", a.scnt, e.scnt);
         chk("dut3_flush_count", a.fcnt, e.fcnt);
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      model_clear(0);
      model_clear(1);
      reset = 1'b0;
      idle();
      @(posedge clk);
      #1;
      do_reset();

      // ALU-stage writer forwarded to src1, no stall
      issue(1, 0, 3'd3);
      idle(); dec_valid = 1; dec_src1 = 3'd3; dec_src1_used = 1;
      #2;
      chk("alu_fwd_sel1", {14'd0, f1_1}, 16'h1);
      chk("alu_fwd_no_stall", {15'd0, sd1}, 16'h0);
      cycle();

      // Load-use: one stall cycle, then memory-stage forward
      do_reset();
      issue(1, 1, 3'd2);
      idle(); dec_valid = 1; dec_wb = 1; dec_dst = 3'd4; dec_src2 = 3'd2; dec_src2_used = 1;
      #2;
      chk("lu_stall", {13'd0, sf1, sd1, bx1}, 16'h7);
      cycle();
      chk("lu_release", {15'd0, sd1}, 16'h0);
      chk("lu_fwd_sel2", {14'd0, f2_1}, 16'h2);
      chk("lu_stall_count", sc1, 16'h1);
      cycle();

      // Load-use coinciding with a taken jump: flush wins
      do_reset();
      issue(1, 1, 3'd2);
      idle(); dec_valid = 1; dec_src2 = 3'd2; dec_src2_used = 1; ex_jump_taken = 1;
      #2;
      chk("jmp_flush", {14'd0, ffd1, fde1}, 16'h3);
      chk("jmp_no_stall", {15'd0, sd1}, 16'h0);
      chk("jmp_fwd_suppressed", {14'd0, f2_1}, 16'h0);
      cycle();
      idle();
      #2;
      chk("jmp_flush_count", fc1, 16'h1);
      chk("jmp_flush_one_cycle", {14'd0, ffd1, fde1}, 16'h0);
      cycle();

      // Forwarding priority E > M > W
      do_reset();
      issue(1, 0, 3'd5);
      issue(1, 0, 3'd5);
      issue(1, 0, 3'd5);
      idle(); dec_src1 = 3'd5; dec_src1_used = 1;
      #2;
      chk("prio_e", {14'd0, f1_1}, 16'h1);
      cycle();
      chk("prio_m", {14'd0, f1_1}, 16'h2);
      cycle();
      chk("prio_w", {14'd0, f1_1}, 16'h3);
      cycle();
      idle();
      cycle();

      // Three-cycle load stall on dut3
      do_reset();
      issue(1, 1, 3'd2);
      idle(); dec_valid = 1; dec_wb = 1; dec_dst = 3'd4; dec_src2 = 3'd2; dec_src2_used = 1;
      #2;
      chk("ls3_c1", {15'd0, sd3}, 16'h1);
      cycle();
      chk("ls3_c2", {15'd0, sd3}, 16'h1);
      chk("ls3_c2_state", {15'd0, dbg3 == ST_STALL}, 16'h1);
      cycle();
      chk("ls3_c3", {15'd0, sd3}, 16'h1);
      cycle();
      chk("ls3_c4_released", {15'd0, sd3}, 16'h0);
      chk("ls3_count", {12'd0, sc3}, 16'h3);
      cycle();

      // Reset asserted in the second stall cycle
      do_reset();
      issue(1, 1, 3'd2);
      idle(); dec_valid = 1; dec_wb = 1; dec_dst = 3'd4; dec_src2 = 3'd2; dec_src2_used = 1;
      cycle();
      reset = 1'b0;
      #1;
      chk("rst_outputs", {7'd0, sf3, sd3, bx3, ffd3, fde3, f1_3, f2_3}, 16'h0);
      chk("rst_state", {15'd0, dbg3 == ST_STALL}, 16'h0);
      chk("rst_counts", {8'd0, sc3, fc3}, 16'h0);
      cycle();
      reset = 1'b1;
      idle();
      cycle();

      // Saturation of the 4-bit stall counter on dut3
      do_reset();
      idle(); dec_valid = 1; dec_wb = 1; dec_mem_read = 1; dec_dst = 3'd1;
      dec_src1 = 3'd1; dec_src1_used = 1;
      repeat (40) cycle();
      chk("sat_full", {12'd0, sc3}, 16'hf);
      repeat (4) cycle();
      chk("sat_hold", {12'd0, sc3}, 16'hf);
      idle();
      cycle();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         reset         = ($urandom_range(0, 99) != 0);
         dec_valid     = 1'($urandom_range(0, 1));
         dec_wb        = ($urandom_range(0, 3) != 0);
         dec_mem_read  = 1'($urandom_range(0, 1));
         dec_src1      = 3'($urandom_range(0, 7));
         dec_src2      = 3'($urandom_range(0, 7));
         dec_dst       = 3'($urandom_range(0, 7));
         dec_src1_used = 1'($urandom_range(0, 1));
         dec_src2_used = 1'($urandom_range(0, 1));
         ex_jump_taken = ($urandom_range(0, 7) == 0);
         cycle();
      end
      reset = 1'b1;
      idle();
      cycle();
      @(negedge clk);
      #1;

      chk("queue1_drained", 16'(exp_q1.size()), 16'h0);
      chk("queue3_drained", 16'(exp_q3.size()), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
